// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU encodings, flag indices and datapath widths
package alu_pkg;

   localparam int XLEN = 32;
   localparam int FLGW = 4;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_OR  = 2'b11
   } alu_ctl_e;

   localparam int FLG_N = 3;
   localparam int FLG_Z = 2;
   localparam int FLG_C = 1;
   localparam int FLG_V = 0;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with combinational head read and clear
module sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata,
   output logic [CW-1:0] count
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   // storage write; contents need no reset because count gates every read
   always_ff @(posedge clk) begin
      if (push && !clr) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // pointers wrap naturally at DEPTH; clear returns both to zero
   always_ff @(posedge clk) begin
      if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
   end

   // occupancy; simultaneous push and pop leaves it unchanged
   always_ff @(posedge clk) begin
      if (clr) begin
         count <= '0;
      end else begin
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign rdata = mem[rd_ptr];

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - queued issue of ALU ops with a registered result slot
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAGW  = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   in_vld,
   output logic                   in_rdy,
   input  logic [1:0]             in_ctl,
   input  logic [XLEN-1:0]        in_op1,
   input  logic [XLEN-1:0]        in_op2,
   input  logic [TAGW-1:0]        in_tag,
   output logic [1:0]             alu_ctl,
   output logic [XLEN-1:0]        alu_op1,
   output logic [XLEN-1:0]        alu_op2,
   input  logic [XLEN-1:0]        alu_res,
   input  logic [FLGW-1:0]        alu_flgs,
   output logic                   out_vld,
   input  logic                   out_rdy,
   output logic [XLEN-1:0]        out_res,
   output logic [FLGW-1:0]        out_flgs,
   output logic [TAGW-1:0]        out_tag,
   output logic [$clog2(DEPTH):0] count
);

   localparam int CW    = $clog2(DEPTH) + 1;
   localparam int ENT_W = TAGW + 2 + 2 * XLEN;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   // entry layout, msb first: tag, ctl, op1, op2
   logic [ENT_W-1:0] wr_ent;
   logic [ENT_W-1:0] head;
   logic             has_head;
   logic             push;
   logic             adv;
   logic             fifo_clr;

   assign wr_ent   = {in_tag, in_ctl, in_op1, in_op2};
   assign has_head = (count != '0);

   // accept does not look at a same-cycle pop: a full queue refuses even while draining
   assign in_rdy   = (count != FULL_CNT) & rst_n & ~flush;
   assign push     = in_vld & in_rdy;
   assign adv      = has_head & (~out_vld | out_rdy);
   assign fifo_clr = ~rst_n | flush;

   sync_fifo #(
      .W     (ENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .clr   (fifo_clr),
      .push  (push),
      .pop   (adv),
      .wdata (wr_ent),
      .rdata (head),
      .count (count)
   );

   // head entry drives the ALU; an empty queue presents all zeros
   always_comb begin
      alu_ctl = '0;
      alu_op1 = '0;
      alu_op2 = '0;
      if (has_head) begin
         alu_ctl = head[2*XLEN +: 2];
         alu_op1 = head[XLEN +: XLEN];
         alu_op2 = head[0 +: XLEN];
      end
   end

   // result slot: capture on advance, drop valid once consumed, data holds after drain
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_vld  <= 1'b0;
         out_res  <= '0;
         out_flgs <= '0;
         out_tag  <= '0;
      end else if (flush) begin
         out_vld  <= 1'b0;
      end else if (adv) begin
         out_vld  <= 1'b1;
         out_res  <= alu_res;
         out_flgs <= alu_flgs;
         out_tag  <= head[ENT_W-1 -: TAGW];
      end else if (out_rdy) begin
         out_vld  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed self-checking bench for alu_issue_stage
module tb_alu_issue_stage;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_vld;
   logic        in_rdy;
   logic [1:0]  in_ctl;
   logic [31:0] in_op1;
   logic [31:0] in_op2;
   logic [3:0]  in_tag;
   logic [1:0]  alu_ctl;
   logic [31:0] alu_op1;
   logic [31:0] alu_op2;
   logic [31:0] alu_res;
   logic [3:0]  alu_flgs;
   logic        out_vld;
   logic        out_rdy;
   logic [31:0] out_res;
   logic [3:0]  out_flgs;
   logic [3:0]  out_tag;
   logic [2:0]  count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_issue_stage #(.DEPTH(4), .TAGW(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .in_vld   (in_vld),
      .in_rdy   (in_rdy),
      .in_ctl   (in_ctl),
      .in_op1   (in_op1),
      .in_op2   (in_op2),
      .in_tag   (in_tag),
      .alu_ctl  (alu_ctl),
      .alu_op1  (alu_op1),
      .alu_op2  (alu_op2),
      .alu_res  (alu_res),
      .alu_flgs (alu_flgs),
      .out_vld  (out_vld),
      .out_rdy  (out_rdy),
      .out_res  (out_res),
      .out_flgs (out_flgs),
      .out_tag  (out_tag),
      .count    (count)
   );

   // reference ALU sitting outside the stage, flags {N,Z,C,V}, C = no-borrow on SUB
   logic [32:0] sum;
   logic [31:0] r;
   logic        c;
   logic        v;
   always_comb begin
      sum = '0;
      r   = '0;
      c   = 1'b0;
      v   = 1'b0;
      case (alu_ctl)
         2'b00: begin
            sum = {1'b0, alu_op1} + {1'b0, alu_op2};
            r   = sum[31:0];
            c   = sum[32];
            v   = (alu_op1[31] == alu_op2[31]) && (r[31] != alu_op1[31]);
         end
         2'b01: begin
            r = alu_op1 - alu_op2;
            c = (alu_op1 >= alu_op2);
            v = (alu_op1[31] != alu_op2[31]) && (r[31] != alu_op1[31]);
         end
         2'b10:   r = alu_op1 & alu_op2;
         default: r = alu_op1 | alu_op2;
      endcase
      alu_res  = r;
      alu_flgs = {r[31], (r == 32'h0), c, v};
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [1:0] ctl, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] t);
      in_vld = v;
      in_ctl = ctl;
      in_op1 = a;
      in_op2 = b;
      in_tag = t;
   endtask

   initial begin
      rst_n   = 1'b0;
      flush   = 1'b0;
      out_rdy = 1'b0;
      drive(1'b0, 2'b00, 32'h0, 32'h0, 4'h0);
      repeat (3) @(negedge clk);
      #1;
      check("rst_in_rdy", in_rdy, 0);
      check("rst_count", count, 0);
      check("rst_out_vld", out_vld, 0);
      check("rst_out_res", out_res, 0);
      check("rst_out_flgs", out_flgs, 0);
      check("rst_out_tag", out_tag, 0);
      check("rst_alu_op1", alu_op1, 0);
      check("rst_alu_op2", alu_op2, 0);

      // ADD 5+3: accept on the next edge, out_vld two edges later
      rst_n   = 1'b1;
      out_rdy = 1'b1;
      drive(1'b1, ALU_ADD, 32'd5, 32'd3, 4'd1);
      #1;
      check("add_in_rdy", in_rdy, 1);
      @(negedge clk);
      drive(1'b0, 2'b00, 32'h0, 32'h0, 4'h0);
      #1;
      check("add_count_e1", count, 1);
      check("add_alu_op1", alu_op1, 5);
      check("add_alu_op2", alu_op2, 3);
      check("add_vld_early", out_vld, 0);
      @(negedge clk);
      #1;
      check("add_vld", out_vld, 1);
      check("add_res", out_res, 32'h8);
      check("add_flgs", out_flgs, 4'b0000);
      check("add_tag", out_tag, 1);
      check("add_count_e2", count, 0);

      // SUB 3-3 gives Z and C
      drive(1'b1, ALU_SUB, 32'd3, 32'd3, 4'd2);
      @(negedge clk);
      drive(1'b0, 2'b00, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
      #1;
      check("sub_vld", out_vld, 1);
      check("sub_res", out_res, 32'h0);
      check("sub_flgs", out_flgs, 4'b0110);
      check("sub_tag", out_tag, 2);

      // back-to-back ADD, AND, OR at full rate
      drive(1'b1, ALU_ADD, 32'd1, 32'd1, 4'd3);
      #1;
      check("b2b_rdy0", in_rdy, 1);
      @(negedge clk);
      drive(1'b1, ALU_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 4'd4);
      #1;
      check("b2b_rdy1", in_rdy, 1);
      @(negedge clk);
      drive(1'b1, ALU_OR, 32'h1, 32'h2, 4'd5);
      #1;
      check("b2b_rdy2", in_rdy, 1);
      check("b2b_vld0", out_vld, 1);
      check("b2b_res0", out_res, 32'h2);
      check("b2b_tag0", out_tag, 3);
      @(negedge clk);
      drive(1'b0, 2'b00, 32'h0, 32'h0, 4'h0);
      #1;
      check("b2b_vld1", out_vld, 1);
      check("b2b_res1", out_res, 32'h00F000F0);
      check("b2b_tag1", out_tag, 4);
      @(negedge clk);
      #1;
      check("b2b_vld2", out_vld, 1);
      check("b2b_res2", out_res, 32'h3);
      check("b2b_tag2", out_tag, 5);
      @(negedge clk);
      #1;
      check("b2b_drained", out_vld, 0);

      // backpressure: slot plus four queue entries, then refuse
      out_rdy = 1'b0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         drive(1'b1, ALU_ADD, 32'(i), 32'd100, i[3:0]);
         #1;
         check($sformatf("bp_in_rdy_%0d", i), in_rdy, (i < 5) ? 1 : 0);
      end
      @(negedge clk);
      drive(1'b0, 2'b00, 32'h0, 32'h0, 4'h0);
      #1;
      check("bp_count", count, 4);
      check("bp_vld_hold", out_vld, 1);
      check("bp_tag_hold", out_tag, 0);
      check("bp_res_hold", out_res, 100);
      out_rdy = 1'b1;
      for (int j = 0; j < 5; j++) begin
         #1;
         check($sformatf("bp_out_vld_%0d", j), out_vld, 1);
         check($sformatf("bp_out_tag_%0d", j), out_tag, j);
         check($sformatf("bp_out_res_%0d", j), out_res, 100 + j);
         check($sformatf("bp_rdy_back_%0d", j), in_rdy, (j == 0) ? 0 : 1);
         @(negedge clk);
      end
      #1;
      check("bp_drained_vld", out_vld, 0);
      check("bp_drained_count", count, 0);

      // flush with three queued and one held
      out_rdy = 1'b0;
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, ALU_OR, 32'(k), 32'h0, 4'(8 + k));
         @(negedge clk);
      end
      drive(1'b0, 2'b00, 32'h0, 32'h0, 4'h0);
      #1;
      check("fl_pre_count", count, 3);
      check("fl_pre_vld", out_vld, 1);
      check("fl_pre_tag", out_tag, 8);
      flush = 1'b1;
      drive(1'b1, ALU_ADD, 32'd9, 32'd9, 4'd12);
      #1;
      check("fl_in_rdy", in_rdy, 0);
      @(negedge clk);
      flush = 1'b0;
      drive(1'b0, 2'b00, 32'h0, 32'h0, 4'h0);
      #1;
      check("fl_count", count, 0);
      check("fl_vld", out_vld, 0);
      check("fl_in_rdy_after", in_rdy, 1);
      check("fl_alu_ctl", alu_ctl, 0);
      check("fl_alu_op1", alu_op1, 0);
      check("fl_alu_op2", alu_op2, 0);
      @(negedge clk);
      #1;
      check("fl_no_push", count, 0);

      // reset mid-operation, then a clean op
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, ALU_ADD, 32'(k), 32'd1, 4'(k));
         @(negedge clk);
      end
      drive(1'b0, 2'b00, 32'h0, 32'h0, 4'h0);
      #1;
      check("mr_pre_count", count, 2);
      check("mr_pre_vld", out_vld, 1);
      rst_n = 1'b0;
      #1;
      check("mr_in_rdy", in_rdy, 0);
      @(negedge clk);
      #1;
      check("mr_count", count, 0);
      check("mr_vld", out_vld, 0);
      check("mr_res", out_res, 0);
      check("mr_flgs", out_flgs, 0);
      check("mr_tag", out_tag, 0);
      check("mr_alu_op1", alu_op1, 0);
      rst_n   = 1'b1;
      out_rdy = 1'b1;
      drive(1'b1, ALU_ADD, 32'd7, 32'd0, 4'd6);
      @(negedge clk);
      drive(1'b0, 2'b00, 32'h0, 32'h0, 4'h0);
      #1;
      check("mr_no_stale", out_vld, 0);
      @(negedge clk);
      #1;
      check("mr_fresh_vld", out_vld, 1);
      check("mr_fresh_res", out_res, 32'h7);
      check("mr_fresh_tag", out_tag, 6);
      @(negedge clk);
      #1;
      check("mr_fresh_drain", out_vld, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Buffered issue/retire stage that wraps the 32-bit ALU on both sides. It accepts decoded ALU operations from the decoder over a valid/ready handshake and queues them in an in-order FIFO. The FIFO head drives the ALU operand and control inputs. The ALU's combinational result and flags are captured into a registered output slot that the writeback stage drains over a second valid/ready handshake.

## Interface

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2
- TAGW, 4, width of the destination tag carried alongside each op

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- rst_n  in  1  reset, synchronous and active-low
- flush  in  1  synchronous discard of every queued and held op
- in_vld  in  1  decoder offers an op
- in_rdy  out  1  stage can accept an op
- in_ctl  in  2  ALU op: 00 ADD, 01 SUB, 10 AND, 11 OR
- in_op1, in_op2  in  32  operands
- in_tag  in  TAGW  destination tag
- alu_ctl  out  2  to ALU ctl
- alu_op1, alu_op2  out  32  to ALU operands
- alu_res  in  32  from ALU result
- alu_flgs  in  4  from ALU flags {N,Z,C,V}
- out_vld  out  1  result slot holds a valid result
- out_rdy  in  1  writeback accepts the result
- out_res  out  32  captured result
- out_flgs  out  4  captured flags, bit order {N,Z,C,V}
- out_tag  out  TAGW  tag of the captured op
- count  out  $clog2(DEPTH)+1  FIFO occupancy; excludes the output slot

## Operation

- Push: the FIFO writes in_ctl/op1/op2/tag on an edge where in_vld & in_rdy.
- in_rdy = (count != DEPTH) & rst_n & ~flush.
  - in_rdy does not look at a same-cycle pop. A full FIFO refuses a push even while popping.
- ALU drive: alu_* come combinationally from the head entry when count != 0. When count == 0, all alu_* are 0.
- Retire/pop: define adv = (count != 0) & (~out_vld | out_rdy).
  - On adv, the output slot loads alu_res, alu_flgs and the head tag, out_vld is set to 1, and the head is popped.
- Drain: on an edge with out_vld & out_rdy & ~adv, out_vld clears to 0. out_res, out_flgs and out_tag hold their last values.
- Simultaneous push and pop (not full): count is unchanged and both pointers advance.
- Pointer wrap: read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full and empty are decided by count only.
- Order: results leave strictly in push order. The stage never drops, duplicates or reorders ops.
- Flush: on the next edge, count=0, both pointers=0, out_vld=0.
  - Flush beats push and adv in the same cycle.
  - A result presented with out_vld & out_rdy in the flush cycle counts as consumed.
- Arithmetic: the stage does no arithmetic on data. Result and flags are forwarded unmodified.

## Timing

- Reset: on an edge with rst_n=0, count=0, pointers=0, out_vld=0, out_res=0, out_flgs=0, out_tag=0.
  - While rst_n=0, in_rdy=0. alu_* = 0 from the cycle after the reset edge.
  - Reset asserted mid-operation discards all ops. No partial result is presented.
- Latency: an op pushed on edge E is at the head and driving the ALU during cycle E+1. With the slot free, it is captured on edge E+1, so out_vld is high in the cycle after E+1.
  - Minimum latency is 2 edges from accept to out_vld.
- Throughput: 1 op/cycle sustained while out_rdy=1.
- Backpressure: with out_rdy=0 the stage absorbs DEPTH+1 ops (FIFO plus slot), then in_rdy=0.
- out_* are stable while out_vld=1 & out_rdy=0.

## Structure

- The shared package alu_pkg holds:
  - ctl encodings ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_OR=2'b11
  - flag indices FLG_N=3, FLG_Z=2, FLG_C=1, FLG_V=0
- The ALU itself is instantiated by the parent, not inside this block.
- One sub-module: sync_fifo.
  - Parameterised width/depth.
  - Provides push, pop, count, combinational head read, and synchronous clear used for flush and reset.
- The output slot and adv logic live in alu_issue_stage.

## Test plan

- ADD 5+3, tag 1, out_rdy=1 -> out_vld rises exactly 2 edges after accept; out_res=0x00000008, out_flgs=4'b0000, out_tag=1.
- SUB 3-3, tag 2 -> out_res=0x00000000, out_flgs=4'b0110 (Z=1, C=1).
- Back-to-back pushes of ADD 1+1, AND 0xF0F0F0F0&0x0FF00FF0, OR 0x1|0x2 with out_rdy=1 -> one result per cycle, in order: 0x2, 0x00F000F0, 0x3; in_rdy stays 1.
- out_rdy=0, DEPTH=4, push tags 0..6 -> tags 0..4 accepted, in_rdy=0 from the 5th accept onward, count=4; then out_rdy=1 -> tags 0..4 emerge in order and in_rdy returns to 1 after the first pop.
- Flush while count=3 and out_vld=1 -> next cycle count=0, out_vld=0, in_rdy=1, alu_*=0; a push in the flush cycle is not accepted.
- rst_n=0 for 1 cycle with count=2 and out_vld=1 -> every output at its reset value after the edge, in_rdy=0 during reset, then a fresh ADD 7+0 yields out_res=0x7 with no stale result.
